// File: rtl/inst_fetch_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_fetch_resp_pkg                                    |
// | Description : Shared widths, line-size default and fetch FSM         |
// |               encoding for the instruction-fetch responder.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package inst_fetch_resp_pkg;

    // Instruction address and instruction word widths
    localparam int c_INST_ADDR_W = 32;
    localparam int c_INST_W      = 32;

    // Default number of 32-bit words held in the fetch line
    localparam int c_LINE_WORDS  = 4;

    // Fill state machine: idle/serving hits, issuing a read, waiting for data
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_t;

endpackage : inst_fetch_resp_pkg
`default_nettype wire

// File: rtl/inst_line_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_line_buf                                          |
// | Description : Single fetch line: LINE_WORDS x 32 storage plus tag    |
// |               and valid flag. One write port, one combinational      |
// |               read/compare port.                                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module inst_line_buf
    import inst_fetch_resp_pkg::*;
#(
    parameter int LINE_WORDS = c_LINE_WORDS,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    // Tag capture and valid control
    input  logic                  i_tag_we,
    input  logic [29-OFF_W:0]     i_tag,
    input  logic                  i_valid_set,
    input  logic                  i_valid_clr,
    // Word write port
    input  logic                  i_word_we,
    input  logic [OFF_W-1:0]      i_word_idx,
    input  logic [c_INST_W-1:0]   i_word_data,
    // Combinational read/compare port
    input  logic [29-OFF_W:0]     i_rd_tag,
    input  logic [OFF_W-1:0]      i_rd_idx,
    output logic                  o_hit,
    output logic [c_INST_W-1:0]   o_word,
    output logic [29-OFF_W:0]     o_tag
);

    logic [c_INST_W-1:0] r_words [LINE_WORDS];
    logic [29-OFF_W:0]   r_tag;
    logic                r_valid;

    // Line storage; contents are meaningless until the valid flag is set
    always_ff @(posedge clk) begin
        if (i_word_we) begin
            r_words[i_word_idx] <= i_word_data;
        end
    end

    // Tag and valid flag; a clear request outranks a set request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_tag_we) begin
                r_tag <= i_tag;
            end
            if (i_valid_clr) begin
                r_valid <= 1'b0;
            end else if (i_valid_set) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_hit  = r_valid & (i_rd_tag == r_tag);
    assign o_word = r_words[i_rd_idx];
    assign o_tag  = r_tag;

endmodule : inst_line_buf
`default_nettype wire

// File: rtl/inst_fetch_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_fetch_resp                                        |
// | Description : Instruction-fetch responder. Serves hits from a        |
// |               one-line buffer with zero latency and refills the line |
// |               word by word from a variable-latency backing memory    |
// |               with one outstanding read.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int LINE_WORDS = c_LINE_WORDS
) (
    input  logic                      clk,
    input  logic                      rst,
    // Core fetch port
    input  logic                      ce_i,
    input  logic [c_INST_ADDR_W-1:0]  addr_i,
    output logic [c_INST_W-1:0]       data_o,
    output logic                      stall_req_o,
    input  logic                      flush_i,
    // Backing instruction memory
    output logic                      mem_req_o,
    output logic [c_INST_ADDR_W-1:0]  mem_addr_o,
    input  logic                      mem_rvalid_i,
    input  logic [c_INST_W-1:0]       mem_rdata_i
);

    localparam int OFF_W = $clog2(LINE_WORDS);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [OFF_W-1:0]    r_cnt;
    logic                r_poison;

    logic                w_buf_hit;
    logic [c_INST_W-1:0] w_buf_word;
    logic [29-OFF_W:0]   w_buf_tag;

    logic                w_idle;
    logic                w_hit;
    logic                w_miss_idle;
    logic                w_word_we;
    logic                w_last;
    logic                w_fill_done;
    logic                w_valid_set;
    logic                w_valid_clr;

    // Byte-offset bits of the fetch address carry no information
    logic                w_unused_addr_bits;
    assign w_unused_addr_bits = ^addr_i[1:0];

    assign w_idle      = (r_state == FETCH_IDLE);
    assign w_hit       = ce_i & w_buf_hit & w_idle;
    assign w_miss_idle = ce_i & ~w_buf_hit & w_idle;
    assign w_word_we   = (r_state == FETCH_WAIT) & mem_rvalid_i;
    assign w_last      = (r_cnt == OFF_W'(LINE_WORDS - 1));
    assign w_fill_done = w_word_we & w_last;

    // A new fill invalidates the old line right away so a poisoned fill
    // can never expose a stale line under the new tag.
    assign w_valid_clr = w_miss_idle | (w_idle & flush_i);
    assign w_valid_set = w_fill_done & ~r_poison & ~flush_i;

    inst_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .i_tag_we    (w_miss_idle),
        .i_tag       (addr_i[31:OFF_W+2]),
        .i_valid_set (w_valid_set),
        .i_valid_clr (w_valid_clr),
        .i_word_we   (w_word_we),
        .i_word_idx  (r_cnt),
        .i_word_data (mem_rdata_i),
        .i_rd_tag    (addr_i[31:OFF_W+2]),
        .i_rd_idx    (addr_i[OFF_W+1:2]),
        .o_hit       (w_buf_hit),
        .o_word      (w_buf_word),
        .o_tag       (w_buf_tag)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> REQ -> WAIT, looping until the last word lands
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH_IDLE: begin
                if (w_miss_idle) begin
                    w_state_nxt = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                w_state_nxt = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = w_last ? FETCH_IDLE : FETCH_REQ;
                end
            end
            default: begin
                w_state_nxt = FETCH_IDLE;
            end
        endcase
    end

    // Fill word counter; wraps to zero after the last word of the line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_word_we) begin
            r_cnt <= r_cnt + {{(OFF_W-1){1'b0}}, 1'b1};
        end
    end

    // Poison flag: a flush seen mid-fill keeps the completed line invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_poison <= 1'b0;
        end else if (w_fill_done) begin
            r_poison <= 1'b0;
        end else if (!w_idle && flush_i) begin
            r_poison <= 1'b1;
        end
    end

    // Fetch-port and memory-port outputs
    always_comb begin
        data_o      = '0;
        stall_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        if (w_hit) begin
            data_o = w_buf_word;
        end
        // Stall is forced low while reset is held so the pipeline is not
        // frozen by a reset-time miss.
        stall_req_o = rst & ce_i & ~w_hit;
        if (r_state == FETCH_REQ) begin
            mem_req_o  = 1'b1;
            mem_addr_o = {w_buf_tag, r_cnt, 2'b00};
        end
    end

endmodule : inst_fetch_resp
`default_nettype wire
